// File: rtl/rat_io_hub.sv
// rat_io_hub
//   Parametrised port-I/O hub between the RAT MCU port bus and its peripherals.
//   It provides NUM_OUT write registers, NUM_IN synchronised input ports and a
//   NUM_IRQ-source interrupt controller. The interrupt controller does edge
//   capture and has a mask register and a write-1-to-clear pending register.
//
// Ports
//   CLK        in   1          MCU clock
//   RESET      in   1          asynchronous, active-high reset
//   PORT_ID    in   8          MCU port address
//   OUT_PORT   in   8          MCU write data
//   IO_STRB    in   1          write strobe (level, one write per high cycle)
//   IN_PORT    out  8          read data, combinational from PORT_ID
//   IN_DATA    in   8*NUM_IN   peripheral input bytes (asynchronous)
//   OUT_DATA   out  8*NUM_OUT  output registers
//   OUT_WSTB   out  NUM_OUT    one-cycle pulse per completed write
//   IRQ_SRC    in   NUM_IRQ    interrupt sources (asynchronous, rising edge)
//   INTERRUPT  out  1          registered |(pending & mask)
module rat_io_hub #(
  parameter int         NUM_OUT     = 4,
  parameter int         NUM_IN      = 4,
  parameter int         NUM_IRQ     = 4,
  parameter logic [7:0] OUT_BASE    = 8'h40,
  parameter logic [7:0] IN_BASE     = 8'h20,
  parameter logic [7:0] IRQ_MASK_ID = 8'hF0,
  parameter logic [7:0] IRQ_STAT_ID = 8'hF1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [7:0]           PORT_ID,
  input  logic [7:0]           OUT_PORT,
  input  logic                 IO_STRB,
  output logic [7:0]           IN_PORT,
  input  logic [8*NUM_IN-1:0]  IN_DATA,
  output logic [8*NUM_OUT-1:0] OUT_DATA,
  output logic [NUM_OUT-1:0]   OUT_WSTB,
  input  logic [NUM_IRQ-1:0]   IRQ_SRC,
  output logic                 INTERRUPT
);

  localparam int OUT_LO = int'(OUT_BASE);
  localparam int OUT_HI = OUT_LO + NUM_OUT - 1;
  localparam int IN_LO  = int'(IN_BASE);
  localparam int IN_HI  = IN_LO + NUM_IN - 1;
  localparam int MASK_I = int'(IRQ_MASK_ID);
  localparam int STAT_I = int'(IRQ_STAT_ID);

  function automatic bit ranges_overlap(input int a_lo, input int a_hi,
                                        input int b_lo, input int b_hi);
    return (a_lo <= b_hi) && (b_lo <= a_hi);
  endfunction

  // Configuration sanity checks, evaluated at elaboration time.
  if (NUM_OUT < 1 || NUM_OUT > 16) begin : g_bad_num_out
    $error("rat_io_hub: NUM_OUT must be 1..16");
  end
  if (NUM_IN < 1 || NUM_IN > 16) begin : g_bad_num_in
    $error("rat_io_hub: NUM_IN must be 1..16");
  end
  if (NUM_IRQ < 1 || NUM_IRQ > 8) begin : g_bad_num_irq
    $error("rat_io_hub: NUM_IRQ must be 1..8");
  end
  if (OUT_HI > 255 || IN_HI > 255) begin : g_bad_id_range
    $error("rat_io_hub: port ID range exceeds 8'hFF");
  end
  if (ranges_overlap(OUT_LO, OUT_HI, IN_LO, IN_HI) ||
      ranges_overlap(OUT_LO, OUT_HI, MASK_I, MASK_I) ||
      ranges_overlap(OUT_LO, OUT_HI, STAT_I, STAT_I) ||
      ranges_overlap(IN_LO, IN_HI, MASK_I, MASK_I) ||
      ranges_overlap(IN_LO, IN_HI, STAT_I, STAT_I) ||
      (MASK_I == STAT_I)) begin : g_bad_overlap
    $error("rat_io_hub: port ID ranges overlap");
  end

  logic [NUM_OUT-1:0]  out_hit;
  logic [NUM_IN-1:0]   in_hit;
  logic                mask_hit;
  logic                stat_hit;
  logic [8*NUM_IN-1:0] in_meta;
  logic [8*NUM_IN-1:0] in_sync;
  logic [NUM_IRQ-1:0]  irq_meta;
  logic [NUM_IRQ-1:0]  irq_sync;
  logic [NUM_IRQ-1:0]  irq_prev;
  logic [NUM_IRQ-1:0]  irq_edge;
  logic [NUM_IRQ-1:0]  irq_clear;
  logic [NUM_IRQ-1:0]  irq_mask;
  logic [NUM_IRQ-1:0]  irq_pend;

  // Address decode only; writes additionally qualify with IO_STRB.
  always_comb begin
    out_hit = '0;
    in_hit  = '0;
    for (int k = 0; k < NUM_OUT; k++) out_hit[k] = (PORT_ID == 8'(OUT_LO + k));
    for (int k = 0; k < NUM_IN; k++)  in_hit[k]  = (PORT_ID == 8'(IN_LO + k));
  end

  assign mask_hit  = (PORT_ID == IRQ_MASK_ID);
  assign stat_hit  = (PORT_ID == IRQ_STAT_ID);
  assign irq_clear = (IO_STRB && stat_hit) ? OUT_PORT[NUM_IRQ-1:0] : '0;
  assign irq_edge  = irq_sync & ~irq_prev;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      OUT_DATA <= '0;
      OUT_WSTB <= '0;
    end else begin
      OUT_WSTB <= IO_STRB ? out_hit : '0;
      for (int k = 0; k < NUM_OUT; k++) begin
        if (IO_STRB && out_hit[k]) OUT_DATA[8*k +: 8] <= OUT_PORT;
      end
    end
  end

  // Per-bit two-flop synchronisers; peripherals hold bytes stable long enough
  // that no multi-bit coherency logic is needed.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      in_meta  <= '0;
      in_sync  <= '0;
      irq_meta <= '0;
      irq_sync <= '0;
      irq_prev <= '0;
    end else begin
      in_meta  <= IN_DATA;
      in_sync  <= in_meta;
      irq_meta <= IRQ_SRC;
      irq_sync <= irq_meta;
      irq_prev <= irq_sync;
    end
  end

  // A new edge is OR-ed in after the clear so a simultaneous event is kept.
  // INTERRUPT uses the pre-update pending/mask, giving a one-edge lag.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      irq_mask  <= '0;
      irq_pend  <= '0;
      INTERRUPT <= 1'b0;
    end else begin
      irq_pend  <= (irq_pend & ~irq_clear) | irq_edge;
      INTERRUPT <= |(irq_pend & irq_mask);
      if (IO_STRB && mask_hit) irq_mask <= OUT_PORT[NUM_IRQ-1:0];
    end
  end

  // Read mux; the ID ranges are disjoint, so at most one source matches.
  always_comb begin
    IN_PORT = 8'h00;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_hit[k]) IN_PORT = in_sync[8*k +: 8];
    end
    for (int k = 0; k < NUM_OUT; k++) begin
      if (out_hit[k]) IN_PORT = OUT_DATA[8*k +: 8];
    end
    if (mask_hit) IN_PORT[NUM_IRQ-1:0] = irq_mask;
    if (stat_hit) IN_PORT[NUM_IRQ-1:0] = irq_pend;
  end

endmodule

// File: tb/tb_rat_io_hub.sv
// tb_rat_io_hub
//   Testbench for rat_io_hub with the default parameters: four output ports,
//   four input ports and four interrupt sources.
//   Register-path vectors are table driven. Hand-written sequences cover the
//   multi-cycle corner cases. A scoreboard-checked random phase follows them.
module tb_rat_io_hub;

  logic        CLK;
  logic        RESET;
  logic [7:0]  PORT_ID;
  logic [7:0]  OUT_PORT;
  logic        IO_STRB;
  logic [7:0]  IN_PORT;
  logic [31:0] IN_DATA;
  logic [31:0] OUT_DATA;
  logic [3:0]  OUT_WSTB;
  logic [3:0]  IRQ_SRC;
  logic        INTERRUPT;

  rat_io_hub dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .PORT_ID   (PORT_ID),
    .OUT_PORT  (OUT_PORT),
    .IO_STRB   (IO_STRB),
    .IN_PORT   (IN_PORT),
    .IN_DATA   (IN_DATA),
    .OUT_DATA  (OUT_DATA),
    .OUT_WSTB  (OUT_WSTB),
    .IRQ_SRC   (IRQ_SRC),
    .INTERRUPT (INTERRUPT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int check_count;
  int pass_count;

  typedef struct {
    logic        strb;
    logic [7:0]  id;
    logic [7:0]  wdata;
    logic [7:0]  exp_rd;
    logic [3:0]  exp_wstb;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs[17];

  // Scoreboard state used by the random phase.
  logic [7:0]  m_out[4];
  logic [3:0]  m_mask;
  logic [3:0]  m_pend;
  logic [3:0]  m_wstb;
  logic        m_int;
  logic [3:0]  s1, s2, s3;
  logic [3:0]  ev;
  logic [3:0]  clr;
  logic [31:0] m_in;
  int          act;
  logic        r_strb;
  logic [7:0]  r_id;
  logic [7:0]  r_wd;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic readCheck(input logic [7:0] id, input logic [7:0] exp, input string name);
    PORT_ID = id;
    #1;
    checkOutput(name, {24'h0, IN_PORT}, {24'h0, exp});
  endtask

  task automatic writePort(input logic [7:0] id, input logic [7:0] wd);
    PORT_ID  = id;
    OUT_PORT = wd;
    IO_STRB  = 1'b1;
    tick();
    IO_STRB  = 1'b0;
  endtask

  // Drives one table row, checks the pre-edge read, then the post-edge state.
  task automatic applyStimulus(input vec_t v, input int idx);
    PORT_ID  = v.id;
    OUT_PORT = v.wdata;
    IO_STRB  = v.strb;
    #1;
    checkOutput($sformatf("vec%0d rd", idx), {24'h0, IN_PORT}, {24'h0, v.exp_rd});
    tick();
    checkOutput($sformatf("vec%0d wstb", idx), {28'h0, OUT_WSTB}, {28'h0, v.exp_wstb});
    checkOutput($sformatf("vec%0d out", idx), OUT_DATA, v.exp_out);
  endtask

  function automatic logic [7:0] modelRead(input logic [7:0] id);
    logic [7:0] r;
    r = 8'h00;
    if (id >= 8'h20 && id <= 8'h23) r = m_in[8*id[1:0] +: 8];
    if (id >= 8'h40 && id <= 8'h43) r = m_out[id[1:0]];
    if (id == 8'hF0) r = {4'h0, m_mask};
    if (id == 8'hF1) r = {4'h0, m_pend};
    return r;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    check_count = 0;
    pass_count  = 0;
    RESET    = 1'b0;
    PORT_ID  = 8'h00;
    OUT_PORT = 8'h00;
    IO_STRB  = 1'b0;
    IN_DATA  = 32'h0;
    IRQ_SRC  = 4'h0;
    #1 RESET = 1'b1;
    #2;
    checkOutput("reset OUT_DATA", OUT_DATA, 32'h0);
    checkOutput("reset OUT_WSTB", {28'h0, OUT_WSTB}, 32'h0);
    checkOutput("reset INTERRUPT", {31'h0, INTERRUPT}, 32'h0);
    checkOutput("reset IN_PORT", {24'h0, IN_PORT}, 32'h0);
    @(posedge CLK);
    @(posedge CLK);
    #1 RESET = 1'b0;
    tick();

    // Register writes, pulses, readback and unmapped IDs.
    vecs[0]  = '{1'b1, 8'h42, 8'hC3, 8'h00, 4'b0100, 32'h00C3_0000};
    vecs[1]  = '{1'b0, 8'h42, 8'h00, 8'hC3, 4'b0000, 32'h00C3_0000};
    vecs[2]  = '{1'b1, 8'h40, 8'h11, 8'h00, 4'b0001, 32'h00C3_0011};
    vecs[3]  = '{1'b1, 8'h40, 8'h22, 8'h11, 4'b0001, 32'h00C3_0022};
    vecs[4]  = '{1'b1, 8'h43, 8'h99, 8'h00, 4'b1000, 32'h99C3_0022};
    vecs[5]  = '{1'b1, 8'h44, 8'hFF, 8'h00, 4'b0000, 32'h99C3_0022};
    vecs[6]  = '{1'b1, 8'h3F, 8'hFF, 8'h00, 4'b0000, 32'h99C3_0022};
    vecs[7]  = '{1'b0, 8'h41, 8'h00, 8'h00, 4'b0000, 32'h99C3_0022};
    vecs[8]  = '{1'b1, 8'h41, 8'h5A, 8'h00, 4'b0010, 32'h99C3_5A22};
    vecs[9]  = '{1'b0, 8'h41, 8'h00, 8'h5A, 4'b0000, 32'h99C3_5A22};
    vecs[10] = '{1'b0, 8'h43, 8'h00, 8'h99, 4'b0000, 32'h99C3_5A22};
    vecs[11] = '{1'b0, 8'h24, 8'h00, 8'h00, 4'b0000, 32'h99C3_5A22};
    vecs[12] = '{1'b0, 8'hF0, 8'h00, 8'h00, 4'b0000, 32'h99C3_5A22};
    vecs[13] = '{1'b0, 8'hF1, 8'h00, 8'h00, 4'b0000, 32'h99C3_5A22};
    vecs[14] = '{1'b1, 8'hF0, 8'hFA, 8'h00, 4'b0000, 32'h99C3_5A22};
    vecs[15] = '{1'b0, 8'hF0, 8'h00, 8'h0A, 4'b0000, 32'h99C3_5A22};
    vecs[16] = '{1'b1, 8'hF0, 8'h00, 8'h0A, 4'b0000, 32'h99C3_5A22};
    for (int i = 0; i < 17; i++) applyStimulus(vecs[i], i);
    IO_STRB = 1'b0;

    // Input synchroniser latency.
    IN_DATA = 32'h0000_A500;
    readCheck(8'h21, 8'h00, "sync edge0");
    tick();
    readCheck(8'h21, 8'h00, "sync edge1");
    tick();
    readCheck(8'h21, 8'hA5, "sync edge2");
    readCheck(8'h24, 8'h00, "unmapped 24");
    readCheck(8'h42, 8'hC3, "readback 42");
    tick();

    // Masked event, unmask, then W1C.
    IRQ_SRC = 4'b0100;
    tick();
    readCheck(8'hF1, 8'h00, "irq lat1");
    tick();
    IRQ_SRC = 4'b0000;
    readCheck(8'hF1, 8'h00, "irq lat2");
    tick();
    readCheck(8'hF1, 8'h04, "irq lat3");
    checkOutput("int masked", {31'h0, INTERRUPT}, 32'h0);
    tick();
    checkOutput("int masked later", {31'h0, INTERRUPT}, 32'h0);
    writePort(8'hF0, 8'h04);
    checkOutput("int mask edge", {31'h0, INTERRUPT}, 32'h0);
    tick();
    checkOutput("int unmasked", {31'h0, INTERRUPT}, 32'h1);
    writePort(8'hF1, 8'h04);
    readCheck(8'hF1, 8'h00, "w1c cleared");
    checkOutput("int lag clear", {31'h0, INTERRUPT}, 32'h1);
    tick();
    checkOutput("int dropped", {31'h0, INTERRUPT}, 32'h0);

    // Edge coinciding with a clear of the same bit, then a held source.
    IRQ_SRC = 4'b0001;
    tick();
    tick();
    PORT_ID  = 8'hF1;
    OUT_PORT = 8'h01;
    IO_STRB  = 1'b1;
    tick();
    IO_STRB  = 1'b0;
    readCheck(8'hF1, 8'h01, "edge beats clear");
    writePort(8'hF1, 8'h01);
    readCheck(8'hF1, 8'h00, "w1c held src");
    repeat (20) tick();
    readCheck(8'hF1, 8'h00, "held src one event");
    checkOutput("held src int", {31'h0, INTERRUPT}, 32'h0);
    IRQ_SRC = 4'b0000;
    repeat (3) tick();
    IRQ_SRC = 4'b0001;
    repeat (3) tick();
    readCheck(8'hF1, 8'h01, "rearm event");
    IRQ_SRC = 4'b0000;
    writePort(8'hF1, 8'h01);
    repeat (3) tick();

    // Reset mid-write and mid-pulse with pending and interrupt active.
    writePort(8'hF0, 8'h03);
    IRQ_SRC = 4'b0011;
    repeat (3) tick();
    readCheck(8'hF1, 8'h03, "pend before reset");
    tick();
    checkOutput("int before reset", {31'h0, INTERRUPT}, 32'h1);
    PORT_ID  = 8'h40;
    OUT_PORT = 8'h77;
    IO_STRB  = 1'b1;
    tick();
    checkOutput("wstb before reset", {28'h0, OUT_WSTB}, 32'h1);
    checkOutput("out before reset", OUT_DATA, 32'h99C3_5A77);
    #1 RESET = 1'b1;
    #1;
    checkOutput("async OUT_DATA", OUT_DATA, 32'h0);
    checkOutput("async OUT_WSTB", {28'h0, OUT_WSTB}, 32'h0);
    checkOutput("async INTERRUPT", {31'h0, INTERRUPT}, 32'h0);
    readCheck(8'hF1, 8'h00, "async pending");
    readCheck(8'hF0, 8'h00, "async mask");
    IO_STRB = 1'b0;
    IRQ_SRC = 4'b0010;
    IN_DATA = 32'h4433_2211;
    tick();
    tick();
    RESET = 1'b0;
    repeat (3) tick();
    readCheck(8'hF1, 8'h02, "src high thru reset");
    IRQ_SRC = 4'b0000;
    writePort(8'hF1, 8'h02);
    readCheck(8'hF1, 8'h00, "post reset clear");
    repeat (4) tick();

    // Random mix against the scoreboard.
    for (int k = 0; k < 4; k++) m_out[k] = 8'h00;
    m_mask = 4'h0;
    m_pend = 4'h0;
    m_wstb = 4'h0;
    m_int  = 1'b0;
    s1 = 4'h0;
    s2 = 4'h0;
    s3 = 4'h0;
    m_in = 32'h4433_2211;
    for (int c = 0; c < 150; c++) begin
      act = $urandom_range(0, 5);
      r_wd = 8'($urandom_range(0, 255));
      r_strb = 1'b0;
      r_id = 8'hF1;
      case (act)
        0: begin r_strb = 1'b1; r_id = 8'h40 + 8'($urandom_range(0, 3)); end
        1: begin r_strb = 1'b1; r_id = 8'hF0; end
        2: begin r_strb = 1'b1; r_id = 8'hF1; end
        3: begin
          r_strb = 1'($urandom_range(0, 1));
          case ($urandom_range(0, 3))
            0: r_id = 8'h20 + 8'($urandom_range(0, 3));
            1: r_id = 8'h40 + 8'($urandom_range(0, 3));
            2: r_id = 8'h80;
            default: r_id = 8'h44;
          endcase
        end
        default: r_id = 8'hF1;
      endcase
      if ($urandom_range(0, 3) == 0) IRQ_SRC = 4'($urandom_range(0, 15));
      PORT_ID  = r_id;
      OUT_PORT = r_wd;
      IO_STRB  = r_strb;
      #1;
      checkOutput($sformatf("rnd%0d rd %0h", c, r_id), {24'h0, IN_PORT}, {24'h0, modelRead(r_id)});
      @(posedge CLK);
      ev  = s2 & ~s3;
      clr = (r_strb && r_id == 8'hF1) ? r_wd[3:0] : 4'h0;
      m_int  = |(m_pend & m_mask);
      m_pend = (m_pend & ~clr) | ev;
      if (r_strb && r_id == 8'hF0) m_mask = r_wd[3:0];
      m_wstb = 4'h0;
      if (r_strb && r_id[7:2] == 6'b010000) begin
        m_out[r_id[1:0]]  = r_wd;
        m_wstb[r_id[1:0]] = 1'b1;
      end
      s3 = s2;
      s2 = s1;
      s1 = IRQ_SRC;
      #1;
      checkOutput($sformatf("rnd%0d out", c), OUT_DATA, {m_out[3], m_out[2], m_out[1], m_out[0]});
      checkOutput($sformatf("rnd%0d wstb", c), {28'h0, OUT_WSTB}, {28'h0, m_wstb});
      checkOutput($sformatf("rnd%0d int", c), {31'h0, INTERRUPT}, {31'h0, m_int});
    end
    IO_STRB = 1'b0;

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
